onehot_strobe_decoder: RTL and testbench

Turns a 4-bit index into a registered one-hot 16-bit strobe held for a fixed number of cycles. It is the inverse of the CPU's 16→4 priority encoder: index codes the encoder produces, or the control path issues, become per-line enables for register-file write selects and peripheral selects. A valid/ready handshake accepts one command at a time. An optional burst mode sweeps consecutive lines.

---
 rtl/cpu_sel_pkg.sv | 21 ++
 rtl/onehot_dec4.sv | 20 ++
 rtl/onehot_strobe_decoder.sv | 162 ++++++++++++++++
 tb/tb_onehot_strobe_decoder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_sel_pkg.sv
// cpu_sel_pkg
// Shared select-line definitions for the CPU's 16->4 priority encoder and
// the matching 4->16 strobe decoder, plus the strobe FSM state type.
package cpu_sel_pkg;

    // Width of an encoded line index and number of decoded lines.
    localparam int SEL_W = 4;
    localparam int SEL_N = 16;

    // Strobe FSM: waiting for a command, or driving a strobe slot.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } strobe_state_t;

    // Next consecutive line; 15 wraps naturally to 0 in SEL_W bits.
    function automatic logic [SEL_W-1:0] sel_next(input logic [SEL_W-1:0] idx);
        return idx + SEL_W'(1);
    endfunction

endpackage

// File: rtl/onehot_dec4.sv
// onehot_dec4
// Purely combinational 4->16 shift decode. With en low the output is
// all-zero, which is how a "no line" command is represented.
module onehot_dec4
    import cpu_sel_pkg::*;
(
    input  logic [SEL_W-1:0] idx,
    input  logic             en,
    output logic [SEL_N-1:0] onehot
);

    // Shift a single set bit into position, or emit nothing when disabled.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot = SEL_N'(1) << idx;
        end
    end

endmodule

// File: rtl/onehot_strobe_decoder.sv
// onehot_strobe_decoder
// Accepts a 4-bit line index over a valid/ready handshake and drives a
// registered one-hot 16-bit strobe for PULSE_CYCLES cycles, followed by one
// idle cycle before the next command can be taken.
// Optional feature macro: ONEHOT_STROBE_BURST_EN adds the in_len port and
// sweeps in_len extra consecutive lines (wrapping 15 -> 0) with no gaps.
module onehot_strobe_decoder
    import cpu_sel_pkg::*;
#(
    parameter int PULSE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_idx,
    input  logic             in_none,
`ifdef ONEHOT_STROBE_BURST_EN
    input  logic [SEL_W-1:0] in_len,
`endif
    output logic [SEL_N-1:0] dout,
    output logic             dout_valid,
    output logic             busy
);

    // Hold counter counts down from PULSE_CYCLES-1 to 0 within a slot.
    localparam logic [3:0] RELOAD = 4'(PULSE_CYCLES - 1);

    strobe_state_t    state;
    strobe_state_t    state_d;
    logic [3:0]       cnt;
    logic [3:0]       cnt_d;
    logic [SEL_W-1:0] cur_idx;
    logic [SEL_W-1:0] idx_d;
    logic             cur_none;
    logic             none_d;
    logic             accept;
    logic             slot_end;
    logic             burst_more;
    logic             dec_en;
    logic [SEL_N-1:0] dout_d;

`ifdef ONEHOT_STROBE_BURST_EN
    logic [SEL_W-1:0] remaining;
    logic [SEL_W-1:0] rem_d;

    assign burst_more = (remaining != '0);
`else
    assign burst_more = 1'b0;
`endif

    assign accept   = in_valid && in_ready;
    assign slot_end = (state == HOLD) && (cnt == 4'd0);

    // State register; reset returns to IDLE and drops any partial burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state: leave IDLE on accept, leave HOLD when the last slot ends.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (slot_end && !burst_more) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Command datapath next values: latch at accept, count down in HOLD and
    // step to the next line when a burst slot finishes.
    always_comb begin
        cnt_d  = cnt;
        idx_d  = cur_idx;
        none_d = cur_none;
`ifdef ONEHOT_STROBE_BURST_EN
        rem_d  = remaining;
`endif
        if (accept) begin
            cnt_d  = RELOAD;
            idx_d  = in_idx;
            none_d = in_none;
`ifdef ONEHOT_STROBE_BURST_EN
            rem_d  = in_len;
`endif
        end else if (state == HOLD) begin
            if (cnt != 4'd0) begin
                cnt_d = cnt - 4'd1;
            end
`ifdef ONEHOT_STROBE_BURST_EN
            else if (burst_more) begin
                cnt_d = RELOAD;
                idx_d = sel_next(cur_idx);
                rem_d = remaining - SEL_W'(1);
            end
`endif
        end
    end

    // Command datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 4'd0;
            cur_idx  <= '0;
            cur_none <= 1'b0;
        end else begin
            cnt      <= cnt_d;
            cur_idx  <= idx_d;
            cur_none <= none_d;
        end
    end

`ifdef ONEHOT_STROBE_BURST_EN
    // Remaining extra slots of the current burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
        end else begin
            remaining <= rem_d;
        end
    end
`endif

    // Outputs: handshake and status from state, decode enable from the
    // upcoming state so the registered strobe lines up with HOLD.
    always_comb begin
        in_ready   = (state == IDLE);
        busy       = (state != IDLE);
        dout_valid = (state == HOLD);
        dec_en     = (state_d == HOLD) && !none_d;
    end

    onehot_dec4 u_dec (
        .idx    (idx_d),
        .en     (dec_en),
        .onehot (dout_d)
    );

    // Strobe register so dout is a clean flop output.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else begin
            dout <= dout_d;
        end
    end

endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// tb_onehot_strobe_decoder
// Randomized scoreboard bench: each accepted command pushes its expected
// strobe slots plus the trailing idle cycle; a negedge monitor pops one
// entry per cycle and compares. Works with or without ONEHOT_STROBE_BURST_EN.
module tb_onehot_strobe_decoder;

    localparam int P = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_idx;
    logic        in_none;
    logic [3:0]  in_len;
    logic [15:0] dout;
    logic        dout_valid;
    logic        busy;

    typedef struct {
        logic        v;
        logic [15:0] d;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   model_busy = 0;
    bit   mon_en = 1'b0;

    onehot_strobe_decoder #(.PULSE_CYCLES(P)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .in_none    (in_none),
`ifdef ONEHOT_STROBE_BURST_EN
        .in_len     (in_len),
`endif
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // One comparison: count it, and report any difference.
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Number of extra slots a command asks for in this build.
    function automatic int extraSlots(input logic [3:0] len);
`ifdef ONEHOT_STROBE_BURST_EN
        return int'(len);
`else
        return 0 * int'(len);
`endif
    endfunction

    // Expected response: (L+1) lines of P cycles each, then one idle cycle.
    task automatic pushCommand(input logic [3:0] idx, input bit none, input logic [3:0] len);
        exp_t e;
        int   line;
        for (int k = 0; k <= extraSlots(len); k++) begin
            line = (int'(idx) + k) % 16;
            for (int p = 0; p < P; p++) begin
                e.v = 1'b1;
                e.d = none ? 16'h0 : 16'(32'h1 << line);
                exp_q.push_back(e);
            end
        end
        e.v = 1'b0;
        e.d = 16'h0;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs; model predicts readiness and acceptance.
    task automatic applyStimulus(input bit v, input logic [3:0] idx, input bit none, input logic [3:0] len);
        bit model_ready;
        bit acc;
        in_valid = v;
        in_idx   = idx;
        in_none  = none;
        in_len   = len;
        model_ready = (model_busy == 0);
        checkOutput("in_ready", 32'(in_ready), 32'(model_ready));
        acc = v && model_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            pushCommand(idx, none, len);
            model_busy = (extraSlots(len) + 1) * P;
        end else if (model_busy > 0) begin
            model_busy--;
        end
    endtask

    // Synchronous reset for n cycles; expectations are dropped at the first edge.
    task automatic doReset(input int n);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        model_busy = 0;
        mon_en     = 1'b1;
        repeat (n - 1) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    endtask

    // Monitor: one expected entry per cycle while a command is in flight,
    // otherwise the block must sit idle with a zero strobe.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                checkOutput("dout_valid", 32'(dout_valid), 32'(mon_e.v));
                checkOutput("dout", 32'(dout), 32'(mon_e.d));
                checkOutput("busy", 32'(busy), 32'(mon_e.v));
            end else begin
                checkOutput("idle_dout_valid", 32'(dout_valid), 32'd0);
                checkOutput("idle_dout", 32'(dout), 32'd0);
                checkOutput("idle_busy", 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        int guard;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_idx   = 4'h0;
        in_none  = 1'b0;
        in_len   = 4'h0;

        doReset(3);
        checkOutput("rst_dout", 32'(dout), 32'd0);
        checkOutput("rst_dout_valid", 32'(dout_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        idleCycles(2);

        $display("[TB] single strobe on line A");
        applyStimulus(1'b1, 4'hA, 1'b0, 4'h0);
        idleCycles(6);

        $display("[TB] back-to-back valid on line 0");
        repeat (12) applyStimulus(1'b1, 4'h0, 1'b0, 4'h0);
        idleCycles(5);

        $display("[TB] no-line command");
        applyStimulus(1'b1, 4'h7, 1'b1, 4'h0);
        idleCycles(6);

        $display("[TB] burst from line E with wrap");
        applyStimulus(1'b1, 4'hE, 1'b0, 4'h3);
        idleCycles(20);

        $display("[TB] reset during second burst slot");
        applyStimulus(1'b1, 4'hE, 1'b0, 4'h3);
        idleCycles(P);
        doReset(1);
        idleCycles(10);

        $display("[TB] randomized traffic");
        repeat (1500) begin
            if ($urandom_range(0, 199) == 0) begin
                doReset(int'($urandom_range(1, 3)));
            end else begin
                applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                              $urandom_range(0, 4) == 0, 4'($urandom_range(0, 15)));
            end
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 400) begin
            idleCycles(1);
            guard++;
        end
        checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
